// File: rtl/serve_scheduler_pkg.sv
// Shared definitions for the serve scheduler.
// Holds the FSM state encoding, the default parameter values and the
// minimum serve interval that a programmed interval of zero maps onto.
package serve_scheduler_pkg;

  localparam int DEF_INTERVAL_W  = 16;
  localparam int DEF_ACK_TIMEOUT = 64;
  localparam int DEF_COUNT_W     = 16;

  // A programmed interval of zero would never fire, so it is promoted to this.
  localparam int MIN_INTERVAL = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SERVE,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/interval_timer.sv
// Countdown used to space serve requests.
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous, active-low
//   load     - loads value into the countdown (takes priority over counting)
//   value    - interval to load, expected to be at least 1
//   tick_out - high during the last cycle of the interval, so the owner
//              reacts on the edge that completes exactly 'value' cycles
module interval_timer #(
  parameter int VALUE_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [VALUE_W-1:0] value,
  output logic               tick_out
);

  logic [VALUE_W-1:0] count;

  // Free-running down-counter that parks at zero; the FSM only looks at
  // tick_out while waiting, so counting outside that state is harmless.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tick_out = (count == VALUE_W'(1));

endmodule

// File: rtl/serve_scheduler.sv
// Serve scheduler: issues periodic serve requests to the DataManager,
// waits for each acknowledge, counts acknowledged serves and ends the run
// on data exhaustion or stop. A missing acknowledge is flagged as an error.
// Ports:
//   clock, reset        - system clock and asynchronous active-low reset
//   start, stop         - run control levels (stop wins over start)
//   clear_err           - leaves the error state
//   interval_cfg        - cycles between serves (0 is treated as 1)
//   out_of_data, reg_en - DataManager status and acknowledge
//   serve_reg           - serve request to the DataManager
//   busy, done, err     - run status (done is a one-cycle pulse)
//   served_count        - acknowledged serves in the current run, saturating
module serve_scheduler
  import serve_scheduler_pkg::*;
#(
  parameter int INTERVAL_W  = DEF_INTERVAL_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int COUNT_W     = DEF_COUNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear_err,
  input  logic [INTERVAL_W-1:0] interval_cfg,
  input  logic                  out_of_data,
  input  logic                  reg_en,
  output logic                  serve_reg,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [COUNT_W-1:0]    served_count
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  state_t                state;
  state_t                state_next;
  logic [INTERVAL_W-1:0] interval_q;
  logic [INTERVAL_W-1:0] interval_eff;
  logic [INTERVAL_W-1:0] timer_value;
  logic                  timer_load;
  logic                  tick;
  logic [ACK_W-1:0]      ack_cnt;
  logic                  stop_pending;
  logic                  run_begin;
  logic                  count_inc;

  assign interval_eff = (interval_cfg == '0) ? INTERVAL_W'(MIN_INTERVAL) : interval_cfg;

  // On a fresh start the live configuration is loaded; reloads between
  // serves reuse the value latched at that start.
  assign timer_value = (state == ST_IDLE) ? interval_eff : interval_q;

  interval_timer #(
    .VALUE_W (INTERVAL_W)
  ) u_interval_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .value    (timer_value),
    .tick_out (tick)
  );

  // Next-state logic. A stop seen together with the acknowledge counts as
  // pending, so that handshake still ends the run through DONE.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    run_begin  = 1'b0;
    count_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          run_begin = 1'b1;
          if (out_of_data) begin
            state_next = ST_DONE;
          end else begin
            timer_load = 1'b1;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          state_next = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (reg_en) begin
          count_inc = 1'b1;
          if (out_of_data || stop_pending || stop) begin
            state_next = ST_DONE;
          end else begin
            timer_load = 1'b1;
            state_next = ST_WAIT;
          end
        end else if (ack_cnt == ACK_LAST) begin
          state_next = ST_ERROR;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      ST_ERROR: begin
        if (clear_err) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, registered outputs and run bookkeeping. Outputs are decoded from
  // the next state so they line up with the state register itself.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      serve_reg    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      served_count <= '0;
      interval_q   <= '0;
      ack_cnt      <= '0;
      stop_pending <= 1'b0;
    end else begin
      state     <= state_next;
      serve_reg <= (state_next == ST_SERVE);
      busy      <= (state_next == ST_WAIT) || (state_next == ST_SERVE);
      done      <= (state_next == ST_DONE);
      err       <= (state_next == ST_ERROR);

      if (run_begin) begin
        interval_q   <= interval_eff;
        served_count <= '0;
      end else if (count_inc && (served_count != '1)) begin
        served_count <= served_count + 1'b1;
      end

      // Ack timer and stop request only live for one stay in SERVE.
      if ((state == ST_SERVE) && (state_next == ST_SERVE)) begin
        ack_cnt      <= ack_cnt + 1'b1;
        stop_pending <= stop_pending | stop;
      end else begin
        ack_cnt      <= '0;
        stop_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serve_scheduler.sv
// Self-checking bench for serve_scheduler. The bench plays the DataManager
// and predicts every output from the run rules: serve requests appear a
// whole interval after the start or previous acknowledge, stay up until the
// acknowledge, and the count is the number of acknowledges capped at the
// counter maximum.
module tb_serve_scheduler;

  localparam int INTERVAL_W  = 16;
  localparam int ACK_TIMEOUT = 8;
  localparam int COUNT_W     = 3;
  localparam int COUNT_MAX   = (1 << COUNT_W) - 1;

  logic                  clock;
  logic                  reset;
  logic                  start;
  logic                  stop;
  logic                  clearErr;
  logic [INTERVAL_W-1:0] intervalCfg;
  logic                  outOfData;
  logic                  regEn;
  logic                  serveReg;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [COUNT_W-1:0]    servedCount;

  int vectors;
  int miscompares;

  serve_scheduler #(
    .INTERVAL_W  (INTERVAL_W),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .COUNT_W     (COUNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .clear_err    (clearErr),
    .interval_cfg (intervalCfg),
    .out_of_data  (outOfData),
    .reg_en       (regEn),
    .serve_reg    (serveReg),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .served_count (servedCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic c,
                               input logic o, input logic r);
    start     = s;
    stop      = p;
    clearErr  = c;
    outOfData = o;
    regEn     = r;
  endtask

  function automatic logic [COUNT_W-1:0] expCount(input int acks);
    return COUNT_W'((acks > COUNT_MAX) ? COUNT_MAX : acks);
  endfunction

  task automatic checkOutput(input string tag, input logic s, input logic b,
                             input logic d, input logic e,
                             input logic [COUNT_W-1:0] cnt);
    logic [31:0] observed;
    logic [31:0] expected;
    observed = 32'({serveReg, busy, done, err, servedCount});
    expected = 32'({s, b, d, e, cnt});
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed {serve,busy,done,err,count}=%0h expected %0h",
               tag, observed, expected);
      $error("[TB] %s did not match the model", tag);
    end
  endtask

  // One complete run: start with cfg, acknowledge nAcks serves, raise
  // out_of_data with the last acknowledge. ackDelay 0 picks a random delay
  // per serve, up to the full timeout window.
  task automatic runServe(input int cfg, input int nAcks, input int ackDelay);
    int n;
    int d;
    n = (cfg == 0) ? 1 : cfg;
    intervalCfg = INTERVAL_W'(cfg);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    intervalCfg = INTERVAL_W'($urandom);
    for (int k = 1; k <= nAcks; k++) begin
      for (int j = 0; j < n; j++) begin
        checkOutput("wait", 1'b0, 1'b1, 1'b0, 1'b0, expCount(k - 1));
        step();
      end
      d = (ackDelay == 0) ? int'($urandom_range(1, ACK_TIMEOUT)) : ackDelay;
      for (int j = 0; j < d; j++) begin
        checkOutput("serve", 1'b1, 1'b1, 1'b0, 1'b0, expCount(k - 1));
        if (j == d - 1) begin
          applyStimulus(1'b0, 1'b0, 1'b0, (k == nAcks), 1'b1);
        end
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    checkOutput("done_pulse", 1'b0, 1'b0, 1'b1, 1'b0, expCount(nAcks));
    step();
    checkOutput("after_done", 1'b0, 1'b0, 1'b0, 1'b0, expCount(nAcks));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_ack_ignored", 1'b0, 1'b0, 1'b0, 1'b0, expCount(nAcks));
  endtask

  initial begin
    int n;
    int stopAt;
    vectors     = 0;
    miscompares = 0;
    intervalCfg = '0;
    reset       = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    reset = 1'b1;
    step();
    checkOutput("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Interval 4, acknowledge two cycles after each serve, three serves.
    runServe(4, 3, 2);
    // Interval 0 behaves as 1.
    runServe(0, 2, 1);
    // Acknowledge in the last cycle before the timeout, then saturation.
    runServe(1, 2, ACK_TIMEOUT);
    runServe(1, 9, 0);

    // start and stop together: stop wins.
    intervalCfg = 16'd3;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("start_and_stop", 1'b0, 1'b0, 1'b0, 1'b0, expCount(9));
    step();
    checkOutput("start_and_stop_hold", 1'b0, 1'b0, 1'b0, 1'b0, expCount(9));

    // out_of_data at start goes straight to DONE with a cleared count.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ood_start_done", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    step();
    checkOutput("ood_start_idle", 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Stop during WAIT: back to IDLE, no serve, no done.
    n = 5;
    stopAt = int'($urandom_range(0, n - 2));
    intervalCfg = INTERVAL_W'(n);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < stopAt; j++) begin
      checkOutput("wait_before_stop", 1'b0, 1'b1, 1'b0, 1'b0, '0);
      step();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < n + 2; j++) begin
      checkOutput("stopped_in_wait", 1'b0, 1'b0, 1'b0, 1'b0, '0);
      step();
    end

    // Stop during SERVE: the handshake completes, then DONE.
    intervalCfg = 16'd2;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("serve_before_stop", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 1; j <= 3; j++) begin
      checkOutput("serve_stop_pending", 1'b1, 1'b1, 1'b0, 1'b0, '0);
      if (j == 3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("stop_serve_done", 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    step();
    checkOutput("stop_serve_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);

    // Acknowledge never arrives: serve held for the timeout, then ERROR.
    intervalCfg = 16'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int j = 0; j < ACK_TIMEOUT; j++) begin
      checkOutput("serve_no_ack", 1'b1, 1'b1, 1'b0, 1'b0, '0);
      step();
    end
    checkOutput("timeout_err", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("err_ignores_start", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("err_ignores_stop", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clear_err_idle", 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      runServe(int'($urandom_range(0, 6)), int'($urandom_range(1, 10)), 0);
    end

    // Reset in the middle of a handshake clears everything without a clock edge.
    intervalCfg = 16'd2;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("serve_before_reset", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    #1 reset = 1'b0;
    #1 checkOutput("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    reset = 1'b1;
    step();
    step();
    checkOutput("idle_after_async_reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
